// File: rtl/frame_filler_pkg.sv
// Shared frame-buffer constants: FSM encodings, burst geometry and DRAM address layout.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package frame_filler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DATA1 = 2'd2
  } ff_state_t;

  // One row is 1024 pixels of 4 bytes, i.e. 4 KB.
  localparam int ROW_SHIFT       = 12;
  // Pixels per burst (two 128-bit words).
  localparam int BURST_PIX       = 8;
  // The address FIFO takes addresses in 8-byte units.
  localparam int ADDR_UNIT_SHIFT = 3;
  // A 32-byte burst is 4 address units, so xb starts at bit 2.
  localparam int XB_LSB          = 2;
  localparam int Y_LSB           = ROW_SHIFT - ADDR_UNIT_SHIFT;
  localparam int FRAME_LSB       = Y_LSB + 10;

  // Builds {6'b0, frame_sel, y, xb, 2'b00}. The line engine uses the same layout.
  function automatic logic [30:0] fb_addr(input logic [5:0] frame_sel,
                                          input logic [9:0] y,
                                          input logic [6:0] xb);
    fb_addr = (31'(frame_sel) << FRAME_LSB) | (31'(y) << Y_LSB) | (31'(xb) << XB_LSB);
  endfunction

endpackage

// File: rtl/frame_filler_addr_gen.sv
// Burst position counters (xb, y) with end-of-frame detect and DRAM address build.
// Latency: addr/last are combinational from the counters; counters update one cycle after clear/advance.
// Backpressure: none internally; the owner pulses advance only on an accepted final word.
module fb_addr_gen
  import frame_filler_pkg::*;
#(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  input  logic [5:0]  frame_sel,
  output logic [30:0] addr,
  output logic        last
);

  localparam logic [6:0] XB_LAST = 7'(WIDTH / BURST_PIX - 1);
  localparam logic [9:0] Y_LAST  = 10'(HEIGHT - 1);

  logic [6:0] xb;
  logic [9:0] y;

  // Raster-order position: step along the row, then wrap to the next row.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      xb <= '0;
      y  <= '0;
    end else if (advance) begin
      if (xb == XB_LAST) begin
        xb <= '0;
        y  <= y + 10'd1;
      end else begin
        xb <= xb + 7'd1;
      end
    end
  end

  // Final burst of the frame, and the burst address of the current position.
  always_comb begin
    last = (xb == XB_LAST) && (y == Y_LAST);
    addr = fb_addr(frame_sel, y, xb);
  end

endmodule

// File: rtl/frame_filler.sv
// Fills a whole frame buffer with one colour via paired address/write-data FIFO pushes.
// Latency: first push the cycle after acceptance; 2 cycles per burst unstalled.
// Backpressure: CMD waits for both FIFOs not full; DATA1 waits only on the write-data FIFO.
module frame_filler
  import frame_filler_pkg::*;
#(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         FF_valid,
  input  logic [23:0]  FF_color,
  input  logic [31:0]  FF_frame,
  output logic         FF_ready,
  input  logic         af_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  input  logic         wdf_full,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din
);

  ff_state_t   state, state_nxt;
  logic [23:0] color_q;
  logic [5:0]  frame_q;
  logic        accept;
  logic        cmd_push;
  logic        data1_push;
  logic        last;
  logic        advance;

  // Only the 4 MB frame-select bits of the base address matter.
  logic frame_unused;
  assign frame_unused = ^{FF_frame[31:28], FF_frame[21:0]};

  // Request capture and push conditions shared by next-state and output logic.
  always_comb begin
    accept     = (state == ST_IDLE) && FF_valid;
    cmd_push   = (state == ST_CMD) && !af_full && !wdf_full;
    data1_push = (state == ST_DATA1) && !wdf_full;
    advance    = data1_push && !last;
  end

  // State register plus colour/frame latches sampled only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      color_q <= '0;
      frame_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        color_q <= FF_color;
        frame_q <= FF_frame[27:22];
      end
    end
  end

  // Next state: CMD/DATA1 alternate per burst; end-of-frame is checked before advancing.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (FF_valid) state_nxt = ST_CMD;
      ST_CMD:   if (cmd_push) state_nxt = ST_DATA1;
      ST_DATA1: if (data1_push) state_nxt = last ? ST_IDLE : ST_CMD;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: address and word 0 go together; word 1 follows on its own.
  always_comb begin
    FF_ready     = (state == ST_IDLE);
    af_wr_en     = cmd_push;
    wdf_wr_en    = cmd_push || data1_push;
    wdf_din      = {4{8'h00, color_q}};
    wdf_mask_din = 16'h0000;
  end

  fb_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .advance   (advance),
    .frame_sel (frame_q),
    .addr      (af_addr_din),
    .last      (last)
  );

endmodule

// File: tb/tb_frame_filler.sv
// Directed bench: 800x3 filler for address layout, stalls, reset and back-to-back; 16x2 filler for raster order.
// Latency: n/a.
// Backpressure: full flags driven directly by the stimulus.
module tb_frame_filler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         FF_valid = 1'b0;
  logic [23:0]  FF_color = '0;
  logic [31:0]  FF_frame = '0;
  logic         FF_ready;
  logic         af_full = 1'b0;
  logic         af_wr_en;
  logic [30:0]  af_addr_din;
  logic         wdf_full = 1'b0;
  logic         wdf_wr_en;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;

  logic         valid2 = 1'b0;
  logic         ready2;
  logic         af_full2 = 1'b0;
  logic         af_wr_en2;
  logic [30:0]  af_addr_din2;
  logic         wdf_full2 = 1'b0;
  logic         wdf_wr_en2;
  logic [127:0] wdf_din2;
  logic [15:0]  wdf_mask_din2;

  always #5 clk = ~clk;

  frame_filler #(.WIDTH(800), .HEIGHT(3)) dut (
    .clk(clk), .rst(rst), .FF_valid(FF_valid), .FF_color(FF_color), .FF_frame(FF_frame),
    .FF_ready(FF_ready), .af_full(af_full), .af_wr_en(af_wr_en), .af_addr_din(af_addr_din),
    .wdf_full(wdf_full), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din)
  );

  frame_filler #(.WIDTH(16), .HEIGHT(2)) dut_small (
    .clk(clk), .rst(rst), .FF_valid(valid2), .FF_color(FF_color), .FF_frame(FF_frame),
    .FF_ready(ready2), .af_full(af_full2), .af_wr_en(af_wr_en2), .af_addr_din(af_addr_din2),
    .wdf_full(wdf_full2), .wdf_wr_en(wdf_wr_en2), .wdf_din(wdf_din2), .wdf_mask_din(wdf_mask_din2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Push monitor, sampled mid-cycle.
  int           af_cnt = 0, wdf_cnt = 0, split_cnt = 0, bad_dat = 0, bad_mask = 0;
  logic [127:0] exp_dat = '0;
  logic [30:0]  last_addr = '0;
  logic [30:0]  q2[$];

  always @(negedge clk) begin
    if (af_wr_en) begin
      af_cnt++;
      last_addr = af_addr_din;
      if (!wdf_wr_en) split_cnt++;
    end
    if (wdf_wr_en) begin
      wdf_cnt++;
      if (wdf_din !== exp_dat) bad_dat++;
      if (wdf_mask_din !== 16'h0000) bad_mask++;
    end
    if (af_wr_en2) q2.push_back(af_addr_din2);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (FF_ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_cmd(input string tag, input logic [30:0] target, input int budget);
    int i;
    i = 0;
    while (!(af_wr_en === 1'b1 && af_addr_din === target) && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 128'(i < budget), 128'd1);
  endtask

  initial begin
    int n;
    int a0, w0, b0;
    logic [30:0] exp2[4];
    exp2[0] = 31'h00080000;
    exp2[1] = 31'h00080004;
    exp2[2] = 31'h00080200;
    exp2[3] = 31'h00080204;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 128'(FF_ready), 128'd1);
    chk("rst_af_en", 128'(af_wr_en), 128'd0);
    chk("rst_wdf_en", 128'(wdf_wr_en), 128'd0);
    chk("rst_addr", 128'(af_addr_din), 128'd0);
    chk("rst_wdf_din", wdf_din, 128'd0);
    chk("rst_mask", 128'(wdf_mask_din), 128'd0);
    rst = 1'b0;
    tick();

    // Basic fill: red into frame select 1
    FF_frame = 32'h10400000;
    FF_color = 24'hFF0000;
    exp_dat  = {4{32'h00FF0000}};
    a0 = af_cnt; w0 = wdf_cnt;
    FF_valid = 1'b1;
    tick();
    FF_valid = 1'b0;
    chk("acc_ready_low", 128'(FF_ready), 128'd0);
    chk("acc_af_en", 128'(af_wr_en), 128'd1);
    chk("acc_wdf_en", 128'(wdf_wr_en), 128'd1);
    chk("first_addr", 128'(af_addr_din), 128'h00080000);
    chk("first_data", wdf_din, {4{32'h00FF0000}});
    wait_ready(2000, n);
    chk("fill1_cycles", 128'(n), 128'd600);
    chk("fill1_af_pushes", 128'(af_cnt - a0), 128'd300);
    chk("fill1_wdf_pushes", 128'(wdf_cnt - w0), 128'd600);
    chk("fill1_last_addr", 128'(last_addr), 128'h0008058C);
    chk("split_pushes", 128'(split_cnt), 128'd0);
    chk("fill1_bad_data", 128'(bad_dat), 128'd0);

    // Fill 2: blue into frame 0, with both stalls and an ignored request
    FF_frame = 32'h00000000;
    FF_color = 24'h0000FF;
    exp_dat  = {4{32'h000000FF}};
    tick();
    a0 = af_cnt; b0 = bad_dat;
    FF_valid = 1'b1;
    tick();
    FF_valid = 1'b0;
    wait_cmd("reach_burst5", 31'h00000014, 40);
    af_full = 1'b1;
    #1;
    chk("afstall_af_en", 128'(af_wr_en), 128'd0);
    chk("afstall_wdf_en", 128'(wdf_wr_en), 128'd0);
    w0 = wdf_cnt; n = af_cnt;
    repeat (10) tick();
    chk("afstall_no_af", 128'(af_cnt), 128'(n));
    chk("afstall_no_wdf", 128'(wdf_cnt), 128'(w0));
    chk("afstall_addr_held", 128'(af_addr_din), 128'h00000014);
    af_full = 1'b0;
    #1;
    chk("afrel_af_en", 128'(af_wr_en), 128'd1);
    chk("afrel_wdf_en", 128'(wdf_wr_en), 128'd1);
    tick();
    chk("afrel_pushed", 128'(af_cnt), 128'(n + 1));

    wait_cmd("reach_xb99", 31'h0000018C, 400);
    tick();
    wdf_full = 1'b1;
    #1;
    chk("wdfstall_wdf_en", 128'(wdf_wr_en), 128'd0);
    chk("wdfstall_af_en", 128'(af_wr_en), 128'd0);
    repeat (3) tick();
    chk("wdfstall_still_data1", 128'({af_wr_en, wdf_wr_en, FF_ready}), 128'd0);
    chk("wdfstall_addr_held", 128'(af_addr_din), 128'h0000018C);
    wdf_full = 1'b0;
    #1;
    chk("wdfrel_wdf_en", 128'(wdf_wr_en), 128'd1);
    tick();
    chk("row_wrap_addr", 128'(af_addr_din), 128'h00000200);
    chk("row_wrap_af_en", 128'(af_wr_en), 128'd1);

    FF_valid = 1'b1;
    FF_color = 24'h00FF00;
    tick();
    tick();
    FF_valid = 1'b0;
    wait_ready(2000, n);
    chk("fill2_af_pushes", 128'(af_cnt - a0), 128'd300);
    chk("fill2_colour_kept", 128'(bad_dat - b0), 128'd0);

    // Reset mid-fill at burst 150 (xb=50, y=1)
    FF_frame = 32'h10400000;
    FF_color = 24'h123456;
    exp_dat  = {4{32'h00123456}};
    FF_valid = 1'b1;
    tick();
    FF_valid = 1'b0;
    wait_cmd("reach_burst150", 31'h000802C8, 400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_af_en", 128'(af_wr_en), 128'd0);
    chk("midrst_wdf_en", 128'(wdf_wr_en), 128'd0);
    chk("midrst_ready", 128'(FF_ready), 128'd1);
    a0 = af_cnt;
    FF_valid = 1'b1;
    tick();
    FF_valid = 1'b0;
    chk("restart_addr", 128'(af_addr_din), 128'h00080000);
    chk("restart_data", wdf_din, {4{32'h00123456}});

    // Back-to-back: request held across completion
    wait_cmd("reach_last", 31'h0008058C, 700);
    FF_valid = 1'b1;
    tick();
    chk("b2b_data1_busy", 128'(FF_ready), 128'd0);
    tick();
    chk("b2b_idle_ready", 128'(FF_ready), 128'd1);
    chk("fill3_af_pushes", 128'(af_cnt - a0), 128'd300);
    tick();
    FF_valid = 1'b0;
    chk("b2b_restart", 128'({FF_ready, af_wr_en, af_addr_din}), 128'({1'b0, 1'b1, 31'h00080000}));
    a0 = af_cnt;
    wait_ready(2000, n);
    chk("b2b_af_pushes", 128'(af_cnt - a0), 128'd300);
    chk("bad_mask", 128'(bad_mask), 128'd0);
    chk("split_pushes_end", 128'(split_cnt), 128'd0);

    // Small geometry: 2 bursts per row, 2 rows
    valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    n = 0;
    while (ready2 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("small_cycles", 128'(n), 128'd8);
    chk("small_bursts", 128'(q2.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("small_addr%0d", i), 128'((q2.size() > i) ? q2[i] : 31'h7FFFFFFF), 128'(exp2[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_filler.md
# frame_filler

Fills one complete frame buffer in DRAM with a single 24-bit colour. It sits directly downstream of the graphics command processor and consumes its `FF_valid`/`FF_ready`/`FF_color`/`FF_frame` handshake. It sits upstream of the DRAM request arbiter: it drives the address FIFO and the write-data FIFO.

## Interface
Parameters:
- `WIDTH`, 800: visible pixels per row; must be a multiple of 8.
- `HEIGHT`, 600: visible rows.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `FF_valid`  in  1  fill request from the command processor.
- `FF_color`  in  24  fill colour, RGB 8:8:8.
- `FF_frame`  in  32  frame base byte address; only bits [27:22] are used.
- `FF_ready`  out  1  high when idle and able to accept a request.
- `af_full`  in  1  address FIFO full.
- `af_wr_en`  out  1  address FIFO push.
- `af_addr_din`  out  31  burst address.
- `wdf_full`  in  1  write-data FIFO full.
- `wdf_wr_en`  out  1  write-data FIFO push.
- `wdf_din`  out  128  write data.
- `wdf_mask_din`  out  16  byte mask; a 1 suppresses that byte.

## Operation
- **Pixel format:** 32 bits, `{8'h00, color}`.
- **Burst unit:** 8 pixels, written as two 128-bit words.
- **Row stride:** 1024 pixels, i.e. 4 KB per row.
- **Address:** `af_addr_din = {6'b0, frame_q[27:22], y[9:0], xb[6:0], 2'b00}`.
  - `xb` is the burst index within the row, 0..WIDTH/8-1.
  - `y` is 0..HEIGHT-1.
- **Data and mask:**
  - `wdf_din = {4{8'h00, color_q}}` for both words.
  - `wdf_mask_din = 16'h0000` at all times.
- **FSM states:**
  - IDLE:
    - `FF_ready=1`.
    - When `FF_valid=1`, latch `color_q` and `frame_q`, clear `xb` and `y`, and go to CMD.
  - CMD:
    - Asserts `af_wr_en` and `wdf_wr_en` (data word 0) only when `!af_full && !wdf_full`. Both pushes happen in the same cycle, never one without the other.
    - On the push, go to DATA1; otherwise stay in CMD.
  - DATA1:
    - Asserts `wdf_wr_en` (data word 1) when `!wdf_full`.
    - On the push:
      - If `xb==WIDTH/8-1 && y==HEIGHT-1`, go to IDLE.
      - Otherwise advance the position and go to CMD.
- **Advance rule:**
  - If `xb==WIDTH/8-1`: set `xb=0` and `y=y+1`.
  - Otherwise: `xb=xb+1`.
  - No wrap past the last row; the end-of-frame check precedes the increment.
- **Ignored inputs:**
  - `FF_valid` is ignored outside IDLE.
  - `FF_color` and `FF_frame` are sampled only on acceptance; later changes do not affect a fill in progress.

## Timing
- **Reset values:**
  - State = IDLE, `FF_ready=1`, `af_wr_en=0`, `wdf_wr_en=0`, `xb=0`, `y=0`.
  - `af_addr_din` = 0 and `wdf_din` = 0, since `frame_q` and `color_q` are also reset to 0.
- **Accept:** `FF_valid` is sampled on the edge while in IDLE. `FF_ready` falls in the next cycle, and the first `af_wr_en` can appear in that same cycle.
- **Throughput:** 2 cycles per burst when unstalled. A full default frame is 60000 bursts and 120000 cycles. `FF_ready` returns high the cycle after the final DATA1 push.
- **Stalls:** `af_wr_en` and `wdf_wr_en` are combinational in state and the full flags. While a stall lasts, `af_addr_din` and `wdf_din` stay constant.
- **Full-flag changes:**
  - `af_full` changing while in DATA1 has no effect.
  - `wdf_full` rising in CMD blocks both pushes.
- **Reset mid-fill:** returns to IDLE within one cycle and drops both enables. A new fill restarts at (0,0), with no resumption.
- **Back-to-back fills:** `FF_valid` held high across the completion cycle starts a new fill from the IDLE cycle. The minimum gap is one idle cycle.

## Structure
- **Shared package:** holds the FSM state encodings (IDLE/CMD/DATA1), the row-stride shift (12), and the burst-pixel count (8). The line engine reuses the same address layout.
- **Sub-module:** one natural sub-module, `fb_addr_gen`. It contains the `xb`/`y` counters, the end-of-frame compare, and the address concatenation. Its controls are `clear`/`advance`; its outputs are `addr` and `last`.
- The remainder is the FSM plus the colour/frame latches.

## Test plan
- **Basic fill:** `FF_frame=32'h10400000`, `FF_color=24'hFF0000`, full flags low.
  - First push: `af_addr_din=31'h00080000`, `wdf_din=128'h00FF0000` repeated ×4.
  - Last push: `af_addr_din=31'h000CAF8C`.
  - Counts: exactly 60000 address pushes and 120000 data pushes; `FF_ready` high at cycle 120001 after acceptance.
- **Address-FIFO stall:** hold `af_full=1` for 10 cycles at burst 5. Expect no pushes during the stall, address held at xb=5, and both pushes firing together on release.
- **Data-FIFO stall:** assert `wdf_full` during DATA1 at xb=99,y=0. Expect word 1 to be held, then the next address to become xb=0,y=1 (`...,10'd1,7'd0,...`).
- **Reset mid-fill:** pulse `rst` at burst 1000. Expect enables low and `FF_ready=1` the next cycle. A new request then starts at `31'h00080000`-based (0,0).
- **Ignored request:** pulse `FF_valid` with `FF_color=24'h00FF00` mid-fill. The data must remain the original colour and the burst count must stay 60000.
- **Small-parameter run:** WIDTH=16, HEIGHT=2. Expect exactly 4 bursts at xb/y = (0,0), (1,0), (0,1), (1,1).
